// File: rtl/convolutor_pkg.sv
// convolutor_pkg: shared state type, mode constants and arithmetic helpers for the convolution coprocessor
package convolutor_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, MAC, WRITE, DONE} state_t;
  localparam logic MODE_FULL = 1'b0;
  localparam logic MODE_VALID = 1'b1;
  function automatic int acc_width(input int dw, input int aw);
    return 2*dw + aw + 1;
  endfunction
  function automatic logic signed [63:0] saturate(input logic signed [63:0] acc, input int zw, input logic sgn);
    logic signed [63:0] hi, lo;
    hi = sgn ? (64'sd1 <<< (zw-1)) - 64'sd1 : (64'sd1 <<< zw) - 64'sd1;
    lo = sgn ? -(64'sd1 <<< (zw-1)) : 64'sd0;
    return acc > hi ? hi : (acc < lo ? lo : acc);
  endfunction
endpackage

// File: rtl/convolutor_mac.sv
// convolutor_mac: signed/unsigned multiply-accumulate with clear, enable and saturated output of the next accumulator value
module convolutor_mac import convolutor_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int Z_WIDTH = 16,
  parameter int ACC_WIDTH = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [Z_WIDTH-1:0]    o_z
);
  logic signed [DATA_WIDTH:0] w_a, w_b;
  logic signed [2*DATA_WIDTH+1:0] w_prod;
  logic signed [ACC_WIDTH-1:0] r_acc, w_acc_nx;
  always_comb begin
    w_a = {i_signed & i_a[DATA_WIDTH-1], i_a};
    w_b = {i_signed & i_b[DATA_WIDTH-1], i_b};
    w_prod = w_a * w_b;
    w_acc_nx = i_en ? r_acc + ACC_WIDTH'(w_prod) : r_acc;
    o_z = Z_WIDTH'(saturate(64'(w_acc_nx), Z_WIDTH, i_signed));
  end
  always_ff @(posedge clk) r_acc <= (rst || i_clr) ? '0 : w_acc_nx;
endmodule

// File: rtl/convolutor_param.sv
// convolutor_param: runtime-sized full/valid convolution over external X/Y RAMs, writing saturated Z samples
module convolutor_param import convolutor_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int Z_WIDTH = 16,
  parameter int ACC_WIDTH = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   sizeX,
  input  logic [ADDR_WIDTH:0]   sizeY,
  input  logic                  mode_valid,
  input  logic                  signed_mode,
  output logic [ADDR_WIDTH-1:0] memX_addr,
  input  logic [DATA_WIDTH-1:0] dataX,
  output logic [ADDR_WIDTH-1:0] memY_addr,
  input  logic [DATA_WIDTH-1:0] dataY,
  output logic [ADDR_WIDTH:0]   memZ_addr,
  output logic [Z_WIDTH-1:0]    dataZ,
  output logic                  writeZ,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int NW = ADDR_WIDTH + 2;
  state_t r_state;
  logic [NW-1:0] r_sx, r_sy, r_n, r_nf, r_nl, r_k, r_khi;
  logic [NW-1:0] w_nf, w_nl, w_nt, w_klo, w_khi, w_kn;
  logic r_mv, r_sg, r_tail, r_vld, w_illegal;
  logic [Z_WIDTH-1:0] w_z;
  always_comb begin
    w_illegal = sizeX == '0 || sizeY == '0 || (mode_valid == MODE_VALID && sizeX < sizeY);
    w_nf = r_mv == MODE_VALID ? r_sy - NW'(1) : '0;
    w_nl = r_mv == MODE_VALID ? r_sx - NW'(1) : r_sx + r_sy - NW'(2);
    w_nt = r_state == SETUP ? w_nf : r_n + NW'(1);
    w_klo = w_nt + NW'(1) >= r_sy ? w_nt + NW'(1) - r_sy : '0;
    w_khi = w_nt < r_sx - NW'(1) ? w_nt : r_sx - NW'(1);
    w_kn = r_k + NW'(1);
  end
  convolutor_mac #(.DATA_WIDTH(DATA_WIDTH), .Z_WIDTH(Z_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk(clk),
    .rst(rst),
    .i_clr(r_state == SETUP || r_state == WRITE),
    .i_en(r_vld),
    .i_signed(r_sg),
    .i_a(dataX),
    .i_b(dataY),
    .o_z(w_z)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      {r_sx, r_sy, r_n, r_nf, r_nl, r_k, r_khi} <= '0;
      {r_mv, r_sg, r_tail, r_vld} <= '0;
      {memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy, done, err} <= '0;
    end else begin
      done <= 1'b0;
      writeZ <= 1'b0;
      r_vld <= r_state == MAC && !r_tail;
      case (r_state)
        IDLE: if (start) begin
          err <= w_illegal;
          done <= w_illegal;
          r_sx <= NW'(sizeX);
          r_sy <= NW'(sizeY);
          r_mv <= mode_valid;
          r_sg <= signed_mode;
          if (!w_illegal) begin
            busy <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP, WRITE: if (r_state == WRITE && r_n == r_nl) begin
          done <= 1'b1;
          r_state <= DONE;
        end else begin
          r_n <= w_nt;
          r_nf <= w_nf;
          r_nl <= w_nl;
          r_k <= w_klo;
          r_khi <= w_khi;
          r_tail <= 1'b0;
          memX_addr <= ADDR_WIDTH'(w_klo);
          memY_addr <= ADDR_WIDTH'(w_nt - w_klo);
          r_state <= MAC;
        end
        MAC: if (r_tail) begin
          writeZ <= 1'b1;
          memZ_addr <= (ADDR_WIDTH+1)'(r_n - r_nf);
          dataZ <= w_z;
          r_state <= WRITE;
        end else if (r_k == r_khi) begin
          r_tail <= 1'b1;
        end else begin
          r_k <= w_kn;
          memX_addr <= ADDR_WIDTH'(w_kn);
          memY_addr <= ADDR_WIDTH'(r_n - w_kn);
        end
        DONE: begin
          busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_convolutor_param.sv
// tb_convolutor_param: table-driven and randomized checks of convolutor_param against a direct convolution model
module tb_convolutor_param;
  typedef struct {
    int sx, sy;
    bit mv, sg;
    logic [31:0] x, y;
    int nz;
    logic [79:0] z;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, mode_valid = 0, signed_mode = 0;
  logic [5:0] sizeX = 0, sizeY = 0, memZ_addr;
  logic [4:0] memX_addr, memY_addr;
  logic [7:0] dataX, dataY;
  logic [15:0] dataZ;
  logic writeZ, busy, done, err;
  logic [7:0] mx [32], my [32];
  int cyc = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0;
  int base_w, base_d, base_b, n_vec = 0, n_bad = 0;
  int wa [$], wd [$], wc [$];
  vec_t tv [5];
  always #5 clk = ~clk;
  convolutor_param dut (
    .clk(clk), .rst(rst), .start(start), .sizeX(sizeX), .sizeY(sizeY),
    .mode_valid(mode_valid), .signed_mode(signed_mode),
    .memX_addr(memX_addr), .dataX(dataX), .memY_addr(memY_addr), .dataY(dataY),
    .memZ_addr(memZ_addr), .dataZ(dataZ), .writeZ(writeZ),
    .busy(busy), .done(done), .err(err)
  );
  always @(posedge clk) begin
    cyc <= cyc + 1;
    dataX <= mx[memX_addr];
    dataY <= my[memY_addr];
  end
  always @(negedge clk) begin
    if (writeZ) begin
      wa.push_back(int'(memZ_addr));
      wd.push_back(int'(dataZ));
      wc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
  function automatic void chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction
  function automatic longint sv(input logic [7:0] v, input bit sg);
    return sg ? longint'($signed(v)) : longint'(v);
  endfunction
  function automatic longint ref_z(input int n, input int sx, input int sy, input bit sg);
    longint acc = 0;
    for (int k = 0; k < sx; k++)
      if (n - k >= 0 && n - k < sy) acc += sv(mx[k], sg) * sv(my[n-k], sg);
    if (sg) acc = acc > 32767 ? 32767 : (acc < -32768 ? -32768 : acc);
    else acc = acc > 65535 ? 65535 : acc;
    return acc & 64'hFFFF;
  endfunction
  function automatic vec_t mk(input int sx, input int sy, input bit mv, input bit sg,
                              input logic [31:0] x, input logic [31:0] y, input int nz, input logic [79:0] z);
    vec_t v;
    v.sx = sx; v.sy = sy; v.mv = mv; v.sg = sg; v.x = x; v.y = y; v.nz = nz; v.z = z;
    return v;
  endfunction
  task automatic fill_rand();
    for (int i = 0; i < 32; i++) begin
      mx[i] = 8'($urandom);
      my[i] = 8'($urandom);
    end
  endtask
  task automatic run(input int sx, input int sy, input bit mv, input bit sg, input bit hold, output int cs);
    bit ok = 0;
    @(negedge clk);
    base_w = wa.size(); base_d = done_cnt; base_b = busy_cnt;
    sizeX = 6'(sx); sizeY = 6'(sy); mode_valid = mv; signed_mode = sg; start = 1;
    @(negedge clk);
    cs = cyc;
    if (hold) begin
      sizeX = 6'(sx > 1 ? sx - 1 : 32); sizeY = 6'd1; mode_valid = !mv; signed_mode = !sg;
    end else start = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (done) ok = 1;
      else @(negedge clk);
    end
    start = 0;
    #1;
    chk($sformatf("done_seen sx=%0d sy=%0d", sx, sy), longint'(ok), 1);
  endtask
  task automatic check_run(input string tag, input int sx, input int sy, input bit mv, input bit sg, input int cs);
    int nf, nl, t, nt, i;
    nf = mv ? sy - 1 : 0;
    nl = mv ? sx - 1 : sx + sy - 2;
    t = cs;
    chk({tag, " write_count"}, wa.size() - base_w, nl - nf + 1);
    for (int n = nf; n <= nl; n++) begin
      nt = (n < sx - 1 ? n : sx - 1) - (n - sy + 1 > 0 ? n - sy + 1 : 0) + 1;
      t += nt + 2;
      i = base_w + n - nf;
      if (i < wa.size()) begin
        chk($sformatf("%s z_addr n=%0d", tag, n), wa[i], n - nf);
        chk($sformatf("%s z_data n=%0d", tag, n), wd[i], ref_z(n, sx, sy, sg));
        chk($sformatf("%s z_cycle n=%0d", tag, n), wc[i], t);
      end
    end
    chk({tag, " done_cycle"}, done_cyc, t + 1);
    chk({tag, " done_count"}, done_cnt - base_d, 1);
    chk({tag, " busy_cycles"}, busy_cnt - base_b, t + 2 - cs);
    chk({tag, " err"}, err, 0);
  endtask
  initial begin
    int cs, sx, sy, tmp, bw;
    bit mv, sg;
    tv[0] = mk(3, 2, 0, 0, 32'h00030201, 32'h00000101, 4, 80'h0000_0003_0005_0003_0001);
    tv[1] = mk(4, 2, 1, 1, 32'h04030201, 32'h0000FF01, 3, 80'h0000_0000_0001_0001_0001);
    tv[2] = mk(4, 2, 0, 1, 32'h04030201, 32'h0000FF01, 5, 80'hFFFC_0001_0001_0001_0001);
    tv[3] = mk(2, 2, 0, 0, 32'h0000FFFF, 32'h0000FFFF, 3, 80'h0000_0000_FE01_FFFF_FE01);
    tv[4] = mk(2, 2, 0, 1, 32'h00008080, 32'h00008080, 3, 80'h0000_0000_4000_7FFF_4000);
    fill_rand();
    repeat (3) @(negedge clk);
    #1;
    chk("reset outputs", {memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy, done, err}, 0);
    rst = 0;
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 32; i++) begin
        mx[i] = i < 4 ? tv[v].x[8*i +: 8] : 8'h0;
        my[i] = i < 4 ? tv[v].y[8*i +: 8] : 8'h0;
      end
      run(tv[v].sx, tv[v].sy, tv[v].mv, tv[v].sg, 0, cs);
      check_run($sformatf("table%0d", v), tv[v].sx, tv[v].sy, tv[v].mv, tv[v].sg, cs);
      for (int i = 0; i < tv[v].nz; i++)
        if (base_w + i < wa.size())
          chk($sformatf("table%0d z[%0d]", v, i), wd[base_w+i], tv[v].z[16*i +: 16]);
    end
    for (int v = 0; v < 3; v++) begin
      sx = v == 1 ? 2 : 3;
      sy = v == 0 ? 0 : (v == 1 ? 3 : 2);
      run(v == 2 ? 0 : sx, sy, v == 1, 0, 0, cs);
      chk($sformatf("illegal%0d done_cycle", v), done_cyc, cs);
      chk($sformatf("illegal%0d err", v), err, 1);
      chk($sformatf("illegal%0d busy_cycles", v), busy_cnt - base_b, 0);
      @(negedge clk);
      #1;
      chk($sformatf("illegal%0d done_pulse", v), done, 0);
      chk($sformatf("illegal%0d err_held", v), err, 1);
      chk($sformatf("illegal%0d writes", v), wa.size() - base_w, 0);
    end
    fill_rand();
    run(12, 5, 1, 1, 1, cs);
    check_run("held_start", 12, 5, 1, 1, cs);
    repeat (3) @(negedge clk);
    #1;
    chk("held_start single done", done_cnt - base_d, 1);
    chk("held_start idle busy", busy, 0);
    fill_rand();
    @(negedge clk);
    bw = wa.size();
    sizeX = 6'd10; sizeY = 6'd10; mode_valid = 0; signed_mode = 1; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 200 && wa.size() - bw < 2; i++) begin
      @(negedge clk);
      #1;
    end
    chk("pre_reset writes", wa.size() - bw, 2);
    repeat (2) @(negedge clk);
    chk("pre_reset busy", busy, 1);
    rst = 1;
    @(negedge clk);
    #1;
    chk("mid_run reset outputs", {memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy, done, err}, 0);
    rst = 0;
    bw = wa.size();
    repeat (30) @(negedge clk);
    #1;
    chk("post_reset no writes", wa.size() - bw, 0);
    run(10, 10, 0, 1, 0, cs);
    check_run("after_reset", 10, 10, 0, 1, cs);
    for (int r = 0; r < 20; r++) begin
      fill_rand();
      sx = r == 0 ? 32 : r == 1 ? 1 : r == 2 ? 32 : r == 3 ? 1 : int'($urandom_range(1, 32));
      sy = r == 0 ? 32 : r == 1 ? 1 : r == 2 ? 1 : r == 3 ? 32 : int'($urandom_range(1, 32));
      mv = r < 4 ? r[0] : 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      if (mv && sx < sy) begin
        tmp = sx; sx = sy; sy = tmp;
      end
      run(sx, sy, mv, sg, 0, cs);
      check_run($sformatf("rand%0d sx=%0d sy=%0d mv=%0d sg=%0d", r, sx, sy, mv, sg), sx, sy, mv, sg, cs);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
